// File: rtl/count_display_driver.sv
// Binary count -> BCD (double dabble) with 4-digit multiplexed 7-seg scan.
// Optional LEADING_ZERO_BLANK_EN blanks digits above the top nonzero one.
module count_display_driver #(
  parameter int SCAN_DIV    = 12,
  parameter bit SEG_ACT_LOW = 1'b0
) (
  input  logic        clk,
  input  logic        CR,
  input  logic [15:0] det_counter,
  output logic [6:0]  seg,
  output logic [3:0]  Light,
  output logic [15:0] bcd_out,
  output logic        busy,
  output logic        ovf
);

  localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    COMMIT
  } state_t;

  state_t      state, state_nx;
  logic [15:0] shadow, bin;
  logic [19:0] acc, acc_adj;
  logic [3:0]  iter;
  logic        load, step, commit;

  logic [SW-1:0] scan_cnt;
  logic [1:0]    idx, idx_nx;
  logic          tc, blank;
  logic [3:0]    nib;
  logic [6:0]    seg_r, seg_nx;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'd0:    glyph = 7'b0111111;
      4'd1:    glyph = 7'b0000110;
      4'd2:    glyph = 7'b1011011;
      4'd3:    glyph = 7'b1001111;
      4'd4:    glyph = 7'b1100110;
      4'd5:    glyph = 7'b1101101;
      4'd6:    glyph = 7'b1111101;
      4'd7:    glyph = 7'b0000111;
      4'd8:    glyph = 7'b1111111;
      4'd9:    glyph = 7'b1101111;
      default: glyph = 7'b0000000;
    endcase
  endfunction

  always_ff @(posedge clk or posedge CR) begin
    if (CR) state <= IDLE;
    else    state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (det_counter != shadow) state_nx = CONV;
      CONV:   if (iter == 4'd15) state_nx = COMMIT;
      COMMIT: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    load   = 1'b0;
    step   = 1'b0;
    commit = 1'b0;
    unique case (1'b1)
      (state == IDLE):   load   = (det_counter != shadow);
      (state == CONV):   step   = 1'b1;
      (state == COMMIT): commit = 1'b1;
      default: ;
    endcase
  end

  // add-3 correction applied before each shift
  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < 5; i++) begin
      if (acc[4*i +: 4] >= 4'd5)
        acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge CR) begin
    if (CR) begin
      shadow  <= '0;
      bin     <= '0;
      acc     <= '0;
      iter    <= '0;
      bcd_out <= '0;
      busy    <= 1'b0;
      ovf     <= 1'b0;
    end else if (load) begin
      shadow <= det_counter;
      bin    <= det_counter;
      acc    <= '0;
      iter   <= '0;
      busy   <= 1'b1;
    end else if (step) begin
      {acc, bin} <= {acc_adj[18:0], bin, 1'b0};
      iter       <= iter + 4'd1;
    end else if (commit) begin
      bcd_out <= acc[15:0];
      ovf     <= (acc[19:16] != 4'd0);
      busy    <= 1'b0;
    end
  end

  assign tc     = (scan_cnt == SW'(SCAN_DIV - 1));
  assign idx_nx = tc ? idx + 2'd1 : idx;
  assign nib    = bcd_out[4*idx_nx +: 4];

  always_comb begin
    blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    unique case (idx_nx)
      2'd3:    blank = (bcd_out[15:12] == 4'd0);
      2'd2:    blank = (bcd_out[15:8] == 8'd0);
      2'd1:    blank = (bcd_out[15:4] == 12'd0);
      default: blank = 1'b0;
    endcase
`endif
  end

  always_comb begin
    seg_nx = glyph(nib);
    if (ovf)        seg_nx = 7'b1000000;
    else if (blank) seg_nx = 7'b0000000;
  end

  // Light and seg load together so the digit and its glyph never skew
  always_ff @(posedge clk or posedge CR) begin
    if (CR) begin
      scan_cnt <= '0;
      idx      <= '0;
      Light    <= 4'b0001;
      seg_r    <= 7'b0111111;
    end else begin
      scan_cnt <= tc ? '0 : scan_cnt + SW'(1);
      idx      <= idx_nx;
      Light    <= 4'b0001 << idx_nx;
      seg_r    <= seg_nx;
    end
  end

  assign seg = SEG_ACT_LOW ? ~seg_r : seg_r;

endmodule

// File: tb/tb_count_display_driver.sv
// Directed bench for count_display_driver.
// Per-scenario tasks with inline checks.
module tb_count_display_driver;

  localparam int SD = 12;

  logic        clk = 1'b0;
  logic        CR;
  logic [15:0] det_counter;
  logic [6:0]  seg;
  logic [3:0]  Light;
  logic [15:0] bcd_out;
  logic        busy;
  logic        ovf;

  int tests = 0;
  int fails = 0;

  count_display_driver #(
    .SCAN_DIV   (SD),
    .SEG_ACT_LOW(1'b0)
  ) dut (
    .clk        (clk),
    .CR         (CR),
    .det_counter(det_counter),
    .seg        (seg),
    .Light      (Light),
    .bcd_out    (bcd_out),
    .busy       (busy),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  task automatic run_conv(input logic [15:0] v,
                          output int n);
    det_counter = v;
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic chk_conv(input string nm,
                          input logic [15:0] v,
                          input logic [15:0] eb,
                          input logic eo);
    int n;
    run_conv(v, n);
    tests++;
    if (n !== 17) begin
      fails++;
      $display("FAIL %s busy_cycles got %0d want 17",
               nm, n);
    end
    tests++;
    if (bcd_out !== eb || ovf !== eo) begin
      fails++;
      $display("FAIL %s bcd/ovf got %h/%b want %h/%b",
               nm, bcd_out, ovf, eb, eo);
    end
  endtask

  task automatic chk_digit(input string nm,
                           input logic [3:0] lt,
                           input logic [6:0] es);
    int n = 0;
    @(negedge clk);
    while (Light !== lt && n < 5 * SD) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (Light !== lt || seg !== es) begin
      fails++;
      $display("FAIL %s light/seg got %b/%b want %b/%b",
               nm, Light, seg, lt, es);
    end
  endtask

  task automatic test_reset();
    CR = 1'b1;
    det_counter = 16'd0;
    repeat (3) @(negedge clk);
    tests++;
    if (Light !== 4'b0001 || seg !== 7'b0111111 ||
        bcd_out !== 16'h0 || busy !== 1'b0 ||
        ovf !== 1'b0) begin
      fails++;
      $display("FAIL reset got L=%b s=%b b=%h bz=%b o=%b",
               Light, seg, bcd_out, busy, ovf);
    end
    CR = 1'b0;
    for (int k = 0; k < 4; k++) begin
      logic [3:0] el;
      el = 4'b0001 << ((k + 1) % 4);
      repeat (SD) @(negedge clk);
      tests++;
      if (Light !== el) begin
        fails++;
        $display("FAIL scan_%0d got %b want %b",
                 k, Light, el);
      end
    end
  endtask

  task automatic test_conversion();
    chk_conv("conv_1234", 16'd1234, 16'h1234, 1'b0);
    chk_digit("d0_1234", 4'b0001, 7'b1100110);
    chk_digit("d1_1234", 4'b0010, 7'b1001111);
    chk_digit("d2_1234", 4'b0100, 7'b1011011);
    chk_digit("d3_1234", 4'b1000, 7'b0000110);
  endtask

  task automatic test_boundary();
    chk_conv("conv_9999", 16'd9999, 16'h9999, 1'b0);
    chk_digit("d3_9999", 4'b1000, 7'b1101111);
    chk_conv("conv_10000", 16'd10000, 16'h0000, 1'b1);
    for (int k = 0; k < 4; k++)
      chk_digit("dash", 4'b0001 << k, 7'b1000000);
    chk_conv("conv_65535", 16'd65535, 16'h5535, 1'b1);
    chk_digit("dash_max", 4'b0100, 7'b1000000);
  endtask

  task automatic test_mid_change();
    int n = 0;
    det_counter = 16'd5;
    @(negedge clk);
    n = 1;
    repeat (4) begin
      @(negedge clk);
      if (busy) n++;
    end
    det_counter = 16'd7;
    @(negedge clk);
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    tests++;
    if (n !== 17 || bcd_out !== 16'h0005) begin
      fails++;
      $display("FAIL mid_first got n=%0d b=%h want 17/0005",
               n, bcd_out);
    end
    @(negedge clk);
    tests++;
    if (busy !== 1'b1 || bcd_out !== 16'h0005) begin
      fails++;
      $display("FAIL mid_second got bz=%b b=%h want 1/0005",
               busy, bcd_out);
    end
    n = 0;
    while (busy && n < 100) begin
      n++;
      tests++;
      if (bcd_out !== 16'h0005) begin
        fails++;
        $display("FAIL mid_hold got %h want 0005", bcd_out);
      end
      @(negedge clk);
    end
    tests++;
    if (n !== 17 || bcd_out !== 16'h0007) begin
      fails++;
      $display("FAIL mid_final got n=%0d b=%h want 17/0007",
               n, bcd_out);
    end
  endtask

  task automatic test_reset_mid();
    det_counter = 16'd1234;
    @(negedge clk);
    repeat (7) @(negedge clk);
    CR = 1'b1;
    #1;
    tests++;
    if (busy !== 1'b0 || bcd_out !== 16'h0 ||
        Light !== 4'b0001) begin
      fails++;
      $display("FAIL rst_mid got bz=%b b=%h L=%b want 0/0000/0001",
               busy, bcd_out, Light);
    end
    det_counter = 16'd7;
    @(negedge clk);
    CR = 1'b0;
    chk_conv("after_rst", 16'd7, 16'h0007, 1'b0);
  endtask

  task automatic test_leading_zero();
    chk_conv("conv_42", 16'd42, 16'h0042, 1'b0);
`ifdef LEADING_ZERO_BLANK_EN
    chk_digit("lz42_d3", 4'b1000, 7'b0000000);
    chk_digit("lz42_d2", 4'b0100, 7'b0000000);
`else
    chk_digit("lz42_d3", 4'b1000, 7'b0111111);
    chk_digit("lz42_d2", 4'b0100, 7'b0111111);
`endif
    chk_digit("lz42_d1", 4'b0010, 7'b1100110);
    chk_digit("lz42_d0", 4'b0001, 7'b1011011);
    chk_conv("conv_0", 16'd0, 16'h0000, 1'b0);
`ifdef LEADING_ZERO_BLANK_EN
    chk_digit("lz0_d1", 4'b0010, 7'b0000000);
`else
    chk_digit("lz0_d1", 4'b0010, 7'b0111111);
`endif
    chk_digit("lz0_d0", 4'b0001, 7'b0111111);
  endtask

  initial begin
    test_reset();
    test_conversion();
    test_boundary();
    test_mid_change();
    test_reset_mid();
    test_leading_zero();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
